osd_fifo_pkt_sched: RTL

- Packet-granular round-robin scheduler that shares one UDP transmit channel between N_SRC prefetch (show-ahead) byte FIFOs on the OSD stream path.
- Each FIFO has a 2048x8 buffer; the writer side flags when a full packet is buffered.
- The scheduler grants one source, requests a UDP slot and drains exactly PKT_LEN bytes from that source's FIFO read port.
- It then enforces an inter-packet gap.

---
 rtl/osd_fifo_pkt_sched.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/osd_fifo_pkt_sched.sv
// osd_fifo_pkt_sched
// Packet-granular round-robin scheduler that shares one UDP transmit channel
// between N_SRC show-ahead byte FIFOs on the OSD stream path. A source that
// signals a full packet is granted, a UDP slot is requested, exactly PKT_LEN
// bytes are drained from that source's FIFO read port, then an inter-packet
// gap of GAP_CYC idle cycles is inserted.
//
// Ports:
//   clk           single clock
//   rst           synchronous, active-high reset
//   src_rdy       per source: FIFO holds at least PKT_LEN bytes
//   fifo_rd_vld   per source: show-ahead data valid
//   fifo_rd_data  per source: show-ahead byte, source i at [8i+7:8i]
//   fifo_rd_en    per source: pop strobe (only the granted source pops)
//   udp_tx_req    packet request to the UDP stack (held in REQ)
//   udp_tx_ack    one-cycle grant from the UDP stack
//   udp_tx_len    payload length, PKT_LEN while udp_tx_req is high
//   udp_tx_src    granted source index, stable from REQ to end of SEND
//   udp_tx_data   payload byte
//   udp_tx_valid  payload byte valid
//   udp_tx_ready  UDP stack accepts a byte
//   udp_tx_last   marks the final byte of the packet
//   stall_err     sticky: a packet was zero-padded after a FIFO underrun
module osd_fifo_pkt_sched #(
  parameter int N_SRC     = 2,
  parameter int PKT_LEN   = 1024,
  parameter int GAP_CYC   = 12,
  parameter int STALL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_rdy,
  input  logic [N_SRC-1:0]     fifo_rd_vld,
  input  logic [8*N_SRC-1:0]   fifo_rd_data,
  output logic [N_SRC-1:0]     fifo_rd_en,
  output logic                 udp_tx_req,
  input  logic                 udp_tx_ack,
  output logic [15:0]          udp_tx_len,
  output logic [2:0]           udp_tx_src,
  output logic [7:0]           udp_tx_data,
  output logic                 udp_tx_valid,
  input  logic                 udp_tx_ready,
  output logic                 udp_tx_last,
  output logic                 stall_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [11:0] LAST_IDX  = 12'(PKT_LEN - 1);
  localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);
  localparam logic [7:0]  GAP_LAST  = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0]  SRC_LAST  = 3'(N_SRC - 1);
  localparam logic [15:0] LEN_VAL   = 16'(PKT_LEN);

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  rr;         // first source to examine in the next search
  logic [2:0]  sel;        // source committed for the current packet
  logic [11:0] byte_cnt;   // bytes transferred in the current packet
  logic [15:0] stall_cnt;  // consecutive empty cycles, saturating
  logic        pad;        // packet has switched to zero padding
  logic [7:0]  gap_cnt;

  logic        hit;
  logic [2:0]  hit_idx;
  logic        src_vld;
  logic [7:0]  src_data;
  logic        pad_mode;
  logic        xfer;
  logic        last_xfer;

  // Round-robin search without a modulo: first scan sources rr..N_SRC-1,
  // then wrap and scan 0..rr-1; the first ready source wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (!hit && src_rdy[j] && (3'(j) >= rr)) begin
        hit     = 1'b1;
        hit_idx = 3'(j);
      end
    end
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (!hit && src_rdy[j]) begin
        hit     = 1'b1;
        hit_idx = 3'(j);
      end
    end
  end

  // Read-port mux for the committed source.
  always_comb begin
    src_vld  = 1'b0;
    src_data = '0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (sel == 3'(j)) begin
        src_vld  = fifo_rd_vld[j];
        src_data = fifo_rd_data[8*j +: 8];
      end
    end
  end

  // Padding starts on the cycle the stall counter reaches its limit, not one
  // cycle later when the pad flag is registered.
  assign pad_mode  = pad | (stall_cnt >= STALL_LIM);
  assign xfer      = (state == SEND) & udp_tx_valid & udp_tx_ready;
  assign last_xfer = xfer & (byte_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (udp_tx_ack) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: valid/data/pop are a combinational pass-through of the
  // selected FIFO so a byte can move every clock.
  always_comb begin
    udp_tx_req   = 1'b0;
    udp_tx_len   = '0;
    udp_tx_src   = '0;
    udp_tx_data  = '0;
    udp_tx_valid = 1'b0;
    udp_tx_last  = 1'b0;
    fifo_rd_en   = '0;
    case (state)
      REQ: begin
        udp_tx_req = 1'b1;
        udp_tx_len = LEN_VAL;
        udp_tx_src = sel;
      end
      SEND: begin
        udp_tx_src = sel;
        if (pad_mode) begin
          udp_tx_valid = 1'b1;
          udp_tx_data  = '0;
        end else begin
          udp_tx_valid = src_vld;
          udp_tx_data  = src_data;
          for (int unsigned j = 0; j < N_SRC; j++) begin
            fifo_rd_en[j] = (sel == 3'(j)) & src_vld & udp_tx_ready;
          end
        end
        udp_tx_last = udp_tx_valid & (byte_cnt == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= '0;
      sel       <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      pad       <= 1'b0;
      gap_cnt   <= '0;
      stall_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            sel <= hit_idx;
          end
        end
        REQ: begin
          if (udp_tx_ack) begin
            byte_cnt  <= '0;
            stall_cnt <= '0;
            pad       <= 1'b0;
          end
        end
        SEND: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 12'd1;
          end
          if (pad_mode) begin
            pad       <= 1'b1;
            stall_err <= 1'b1;
          end else if (xfer) begin
            stall_cnt <= '0;
          end else if (!src_vld && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
          if (last_xfer) begin
            rr      <= (sel == SRC_LAST) ? 3'd0 : sel + 3'd1;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
